elm_mult_pipe: RTL and testbench

ELM_MULT_PIPE -- requirements
Module: elm_mult_pipe

---
 rtl/elm_mult_pipe.sv | 107 ++++++++++
 tb/tb_elm_mult_pipe.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/elm_mult_pipe.sv
// Three-stage multiplier: exact x*y or Mitchell logarithmic approximation, selected per pair.
// A single advance signal moves every stage together, so the output stalls back-pressure the whole pipe.
module elm_mult_pipe #(
    parameter int WIDTH = 16,
    parameter int W     = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] p_out,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int KW = $clog2(WIDTH);
    localparam int SW = KW + 1;
    localparam int PW = 2 * WIDTH;
    localparam int TW = PW + W + 1;

    function automatic logic [KW-1:0] lead_one(input logic [WIDTH-1:0] v);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) k = KW'(i);
        end
        return k;
    endfunction

    // Normalise so the leading one sits at the MSB, then keep the W bits beneath it.
    function automatic logic [W-1:0] frac(input logic [WIDTH-1:0] v, input logic [KW-1:0] k);
        logic [WIDTH-1:0] n;
        n = v << (WIDTH - 1 - int'(k));
        return n[WIDTH-2 -: W];
    endfunction

    // Antilog: a carry out of the fraction sum doubles the exponent instead of adding the hidden one.
    function automatic logic [PW-1:0] approx_prod(input logic [SW-1:0] k, input logic [W:0] s);
        logic [TW-1:0] t;
        if (s[W])
            t = TW'(s) << (int'(k) + 1);
        else
            t = TW'({1'b1, s[W-1:0]}) << k;
        return PW'(t >> W);
    endfunction

    logic             adv;
    logic             vld_p1, vld_p2;
    logic             mode_p1, mode_p2;
    logic             zero_p1, zero_p2;
    logic [WIDTH-1:0] x_p1, y_p1;
    logic [KW-1:0]    kx_p1, ky_p1;
    logic [W-1:0]     fx_p1, fy_p1;
    logic [PW-1:0]    prod_p2;
    logic [SW-1:0]    ksum_p2;
    logic [W:0]       fsum_p2;
    logic [PW-1:0]    result_p2;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    always_comb begin
        result_p2 = '0;
        if (mode_p2)
            result_p2 = prod_p2;
        else if (!zero_p2)
            result_p2 = approx_prod(ksum_p2, fsum_p2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_valid <= 1'b0;
            p_out     <= '0;
        end else if (adv) begin
            vld_p1    <= in_valid;
            vld_p2    <= vld_p1;
            out_valid <= vld_p2;
            p_out     <= result_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            // stage 1: operands, mode and leading-one decomposition
            x_p1    <= x;
            y_p1    <= y;
            mode_p1 <= mode;
            zero_p1 <= (x == '0) || (y == '0);
            kx_p1   <= lead_one(x);
            ky_p1   <= lead_one(y);
            fx_p1   <= frac(x, lead_one(x));
            fy_p1   <= frac(y, lead_one(y));
            // stage 2: log-domain sum alongside the exact product
            mode_p2 <= mode_p1;
            zero_p2 <= zero_p1;
            prod_p2 <= PW'(x_p1) * PW'(y_p1);
            ksum_p2 <= SW'(kx_p1) + SW'(ky_p1);
            fsum_p2 <= {1'b0, fx_p1} + {1'b0, fy_p1};
        end
    end

endmodule

// File: tb/tb_elm_mult_pipe.sv
// Directed bench for elm_mult_pipe (WIDTH=16, W=5) with hand-computed products and an in-order scoreboard.
module tb_elm_mult_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] p_out;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    elm_mult_pipe #(.WIDTH(16), .W(5)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready),
        .p_out(p_out), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Every transfer is compared against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("stale_result", 64'(p_out), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("result", 64'(p_out), 64'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [15:0] xv, input logic [15:0] yv, input logic mv, input logic [31:0] ev);
        int n;
        n = 0;
        x = xv; y = yv; mode = mv; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        else exp_q.push_back(ev);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_p_out", 64'(p_out), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Latency: accept edge loads stage 1, result valid two edges later.
        x = 16'd3; y = 16'd3; mode = 1'b0; in_valid = 1'b1;
        exp_q.push_back(32'd8);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_edge1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_edge2", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_edge3", 64'(out_valid), 64'd1);
        check("lat_value", 64'(p_out), 64'd8);
        drain();

        send(16'd3, 16'd3, 1'b1, 32'd9);
        send(16'hFFFF, 16'hFFFF, 1'b0, 32'd4160749568);
        send(16'hFFFF, 16'hFFFF, 1'b1, 32'd4294836225);
        send(16'd5, 16'd0, 1'b0, 32'd0);
        send(16'd0, 16'd0, 1'b0, 32'd0);
        drain();

        // Back-to-back stream with alternating mode.
        send(16'd10, 16'd12, 1'b0, 32'd112);
        send(16'd10, 16'd12, 1'b1, 32'd120);
        send(16'd7, 16'd5, 1'b0, 32'd32);
        send(16'd1000, 16'd1000, 1'b1, 32'd1000000);
        send(16'd1, 16'd1, 1'b0, 32'd1);
        send(16'd65535, 16'd1, 1'b1, 32'd65535);
        send(16'd256, 16'd100, 1'b0, 32'd25600);
        send(16'd300, 16'd7, 1'b1, 32'd2100);
        drain();

        // Fill the pipe with the consumer stalled, hold five cycles, then release.
        out_ready = 1'b0;
        send(16'd1000, 16'd1000, 1'b0, 32'd983040);
        send(16'd7, 16'd5, 1'b1, 32'd35);
        send(16'd7, 16'd5, 1'b0, 32'd32);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_p_out", 64'(p_out), 64'd983040);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'hFFFF, 16'hFFFF, 1'b0, 32'd4160749568);
        drain();

        // Reset with three pairs in flight.
        send(16'd300, 16'd7, 1'b1, 32'd2100);
        send(16'd10, 16'd12, 1'b1, 32'd120);
        send(16'd256, 16'd100, 1'b0, 32'd25600);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_p_out", 64'(p_out), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        send(16'd10, 16'd12, 1'b0, 32'd112);
        send(16'd3, 16'd3, 1'b1, 32'd9);
        drain();
        repeat (6) @(posedge clk);
        #1;
        check("idle_out_valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=%0d exp=%0d", checks, 0);
        $fatal(1, "timeout");
    end

endmodule
